// File: rtl/tristate_register.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_register
//  Description : Single-word storage register on a shared bidirectional bus.
//                Byte-lane write enables select which lanes load from the bus;
//                the stored word is always visible on q and is driven onto the
//                bus only during a qualified read (rstn=1, re=1, we=0).
//  Ports       : clk   - rising-edge clock
//                rstn  - synchronous active-low reset
//                re    - read enable (drive bus with stored value)
//                we    - write enable (load enabled lanes from bus)
//                be    - byte-lane enables, bit i covers data[8i+7:8i]
//                data  - shared bidirectional data bus
//                q     - registered stored value, always driven
//  Revision    : 1.0 - initial release
// ============================================================================
module tristate_register #(
    parameter int  WIDTH       = 16,
    parameter      RESET_VALUE = 0,
    localparam int NBE         = (WIDTH + 7) / 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             re,
    input  logic             we,
    input  logic [NBE-1:0]   be,
    inout  wire  [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (WIDTH < 1) begin : g_chk_width
        $error("tristate_register: WIDTH must be at least 1");
    end

    // Any set bit at or above position WIDTH means the reset value would be
    // silently truncated.
    if ((RESET_VALUE >> WIDTH) != 0) begin : g_chk_reset_value
        $error("tristate_register: RESET_VALUE does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(RESET_VALUE);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] store_q;
    logic [WIDTH-1:0] store_d;
    logic             drive_en;

    // Per-lane next-state. The top lane is clipped to WIDTH-1 so that a
    // partial lane only ever touches bits that exist.
    for (genvar i = 0; i < NBE; i++) begin : g_lane
        localparam int LO = 8 * i;
        localparam int HI = ((8 * i + 7) < WIDTH) ? (8 * i + 7) : (WIDTH - 1);

        assign store_d[HI:LO] = (we && be[i]) ? data[HI:LO] : store_q[HI:LO];
    end

    // Reset has priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            store_q <= RESET_WORD;
        end else begin
            store_q <= store_d;
        end
    end

    assign q = store_q;

    // ------------------------------------------------------------------------
    // Bus drive: only on a pure read outside reset. A simultaneous write keeps
    // the bus released so the master's write data never contends with us.
    // ------------------------------------------------------------------------
    assign drive_en = rstn && re && !we;
    assign data     = drive_en ? store_q : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_tristate_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tristate_register
//  Description : Scoreboard bench for tristate_register. Two instances
//                (WIDTH=16 reset 0, WIDTH=12 reset 12'hABC) share control
//                inputs; each has its own bus with a bus-master model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b1;
    logic        re   = 1'b0;
    logic        we   = 1'b0;
    logic [1:0]  be   = 2'b00;

    // Bus master: drives whenever the register is not expected to drive.
    logic        men = 1'b1;
    logic [15:0] m16 = '0;
    logic [11:0] m12 = '0;
    wire  [15:0] bus16;
    wire  [11:0] bus12;
    assign bus16 = men ? m16 : 16'hzzzz;
    assign bus12 = men ? m12 : 12'hzzz;

    logic [15:0] q16;
    logic [11:0] q12;

    tristate_register #(.WIDTH(16), .RESET_VALUE(16'h0000)) u_dut16 (
        .clk  (clk),
        .rstn (rstn),
        .re   (re),
        .we   (we),
        .be   (be),
        .data (bus16),
        .q    (q16)
    );

    tristate_register #(.WIDTH(12), .RESET_VALUE(12'hABC)) u_dut12 (
        .clk  (clk),
        .rstn (rstn),
        .re   (re),
        .we   (we),
        .be   (be),
        .data (bus12),
        .q    (q12)
    );

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic        qk;
        logic [15:0] q16;
        logic [15:0] b16;
        logic [11:0] q12;
        logic [11:0] b12;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] st16;
    logic [11:0] st12;
    logic        known = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit b of the word belongs to byte lane b/8.
    function automatic logic [15:0] lane_merge(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  lanes,
                                               input int          width);
        logic [15:0] r;
        r = old_w;
        for (int b = 0; b < width; b++) begin
            if (lanes[b / 8]) r[b] = new_w[b];
        end
        return r;
    endfunction

    task automatic cycle(input logic r_n, input logic rd, input logic wr,
                         input logic [1:0] b, input logic [15:0] d16,
                         input logic [11:0] d12);
        exp_t        e;
        logic        drv;
        logic [15:0] t;
        @(posedge clk);
        #1;
        rstn = r_n;
        re   = rd;
        we   = wr;
        be   = b;
        drv  = r_n && rd && !wr;
        men  = !drv;
        m16  = wr ? d16 : 16'h0000;
        m12  = wr ? d12 : 12'h000;
        e.qk  = known;
        e.q16 = st16;
        e.q12 = st12;
        e.b16 = drv ? st16 : m16;
        e.b12 = drv ? st12 : m12;
        sb.push_back(e);
        // State seen after the coming edge
        if (!r_n) begin
            st16  = 16'h0000;
            st12  = 12'hABC;
            known = 1'b1;
        end else if (wr) begin
            st16 = lane_merge(st16, d16, b, 16);
            t    = lane_merge({4'h0, st12}, {4'h0, d12}, b, 12);
            st12 = t[11:0];
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("bus16", bus16, e.b16);
            chk("bus12", {4'h0, bus12}, {4'h0, e.b12});
            if (e.qk) begin
                chk("q16", q16, e.q16);
                chk("q12", {4'h0, q12}, {4'h0, e.q12});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int waited;
        // Reset with read, write and all lanes asserted
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 16'h0000, 12'h000);
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 16'h0000, 12'h000);
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 16'h0000, 12'h000);
        // Partial top lane on the 12-bit instance
        cycle(1'b1, 1'b0, 1'b1, 2'b10, 16'hFF00, 12'hFFF);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Full write then read
        cycle(1'b1, 1'b0, 1'b1, 2'b11, 16'hA5C3, 12'h5C3);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Byte-lane writes
        cycle(1'b1, 1'b0, 1'b1, 2'b01, 16'h1234, 12'h234);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        cycle(1'b1, 1'b0, 1'b1, 2'b10, 16'hFF00, 12'hF00);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Idle, then simultaneous read+write
        cycle(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 12'h000);
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 16'h0F0F, 12'hF0F);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Reset mid-operation discards a concurrent write
        cycle(1'b1, 1'b0, 1'b1, 2'b11, 16'hBEEF, 12'hEEF);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 16'h1111, 12'h111);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
                  2'($urandom), 16'($urandom), 12'($urandom));
        end
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 12'h000);
        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
